gaussian_clt_stream: RTL and testbench
======================================

Name: gaussian_clt_stream

Overview:
- Parametrised Central-Limit-Theorem Gaussian noise source with a valid/ready output stream.
- Sums a sliding window of N uniform samples and centres the sum to zero mean. The window uses a running add-newest/subtract-oldest accumulator, not a full re-sum.
- Scales and saturates the result to a signed fixed-point word.
- Sample source is an internal seedable Galois LFSR or an external uniform stream. Feeds the noise-injection datapath in place of the fixed 12-tap generator.

Parameters:
- N_TAPS, 12, window length in samples, legal 2..64.
- U_W, 8, uniform sample width in bits, legal 1..16.
- OUT_W, 16, output word width (Q1.(OUT_W-1)).
- SHIFT, 4, left shift applied to the centred sum before saturation, legal 0..15.
- SEED, 16'hACE1, LFSR reset value.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  advance permission; when low, nothing changes state.
- src_sel  in  1  0 = internal LFSR sample, 1 = ext_sample.
- ext_sample  in  U_W  external uniform sample.
- seed_load  in  1  one-cycle strobe: load seed_in, flush window.
- seed_in  in  16  new LFSR seed.
- out_valid  out  1  out_data holds a valid Gaussian sample.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- out_data  out  OUT_W  signed centred, scaled, saturated sample.
- out_sat  out  1  out_data was clipped; registered with out_data.

Behaviour:
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, toggle mask 16'hB400.
  - Shift right; if LSB is 1, XOR the mask into the shifted value.
  - Uniform sample = lfsr[15 -: U_W] when src_sel=0; else ext_sample.
  - The LFSR steps on every advance, regardless of src_sel.
- advance = enable & !seed_load & (state==FILL | !out_valid | out_ready).
- State machine: FILL, RUN.
- FILL:
  - Each advance pushes one sample; fill_cnt increments.
  - On the advance that makes fill_cnt==N_TAPS, the block registers the output, sets out_valid=1 and moves to RUN.
  - out_valid is therefore first high N_TAPS advancing edges after reset release.
- RUN:
  - On each advance, push the sample, drop the oldest, and register the new out_data/out_sat in the same edge.
  - Throughput is 1 sample/cycle when out_ready is held high.
- Stall: out_valid & !out_ready means no advance. out_data, out_sat, window, sum and LFSR all hold.
- Sum:
  - Width U_W + clog2(N_TAPS) + 1, unsigned.
  - sum_next = sum + new - oldest, where oldest is 0 during FILL.
  - sum always equals the exact window sum; the bench checks this against a full re-sum.
- Centring: c = signed(sum_next) - N_TAPS * 2^(U_W-1). Computed at full width with no truncation before saturation.
- Scaling: s = c <<< SHIFT, computed at width ≥ OUT_W+1.
- Saturation:
  - s > 2^(OUT_W-1)-1 gives max positive with out_sat=1.
  - s < -2^(OUT_W-1) gives min negative with out_sat=1.
  - Otherwise out_data = s and out_sat=0.
- seed_load (priority over advance):
  - Next edge: LFSR <= seed_in, or 16'h0001 if seed_in==0 (lockup guard).
  - Window, sum and fill_cnt cleared; out_valid=0, out_data=0, out_sat=0; state=FILL.
  - An unconsumed pending output is discarded.
- enable low in FILL: fill_cnt holds; the partial window is retained.
- Reset values (async assert, synchronous-safe release):
  - lfsr=SEED (0 replaced by 1).
  - window=0, sum=0, fill_cnt=0, state=FILL.
  - out_valid=0, out_data=0, out_sat=0.
- Reset mid-stream: immediate return to reset values; no output is valid until the window refills.

Test Plan:
- Fill latency (N_TAPS=12, src_sel=1, ext_sample=8'hFF, enable=1, out_ready=1): out_valid=0 for the first 11 edges, 1 at edge 12. out_data=16'h5F40 (sum 3060, c=1524, <<4=24384), out_sat=0.
- Min value (ext_sample=8'h00 for 12 cycles): out_data=16'hA000 (-24576). Then feed 8'h80 for 12 cycles: out_data=0 exactly on the 12th.
- Saturation (SHIFT=5, all 8'hFF): out_data=16'h7FFF, out_sat=1. All 8'h00: out_data=16'h8000, out_sat=1.
- Backpressure (internal LFSR, random out_ready): every accepted word matches the reference model, with no drop or duplicate. During a stall, out_data and the LFSR hold.
- Seed load mid-RUN (seed_in=0): out_valid drops next edge; LFSR becomes 16'h0001; 12 more advances before out_valid. The sequence matches the model seeded with 1.
- Async reset pulse mid-stream (rst_n low for half a cycle): outputs go 0 immediately; refill takes 12 advances. Also check the running sum against a full re-sum over 10,000 cycles at N_TAPS=3 and N_TAPS=64.

Source files
------------

// File: rtl/gaussian_clt_stream_if.sv
`default_nettype none
// ============================================================================
// gaussian_clt_stream_if : valid/ready output stream of the CLT noise source
// Rev 1.0
// ============================================================================
interface gaussian_clt_stream_if #(
    parameter int OUT_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;

    modport master (output out_valid, output out_data, output out_sat, input out_ready);
    modport slave  (input out_valid, input out_data, input out_sat, output out_ready);
endinterface
`default_nettype wire

// File: rtl/gaussian_clt_stream.sv
`default_nettype none
// ============================================================================
// gaussian_clt_stream : sliding-window CLT Gaussian noise source, scaled and
//                       saturated to a signed Q1.(OUT_W-1) valid/ready stream
// Rev 1.0
// ============================================================================
module gaussian_clt_stream #(
    parameter int          N_TAPS = 12,
    parameter int          U_W    = 8,
    parameter int          OUT_W  = 16,
    parameter int          SHIFT  = 4,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           enable,
    input  wire logic           src_sel,
    input  wire logic [U_W-1:0] ext_sample,
    input  wire logic           seed_load,
    input  wire logic [15:0]    seed_in,
    gaussian_clt_stream_if.master out_if
);
    localparam int CNT_W = $clog2(N_TAPS + 1);
    localparam int SUM_W = U_W + $clog2(N_TAPS) + 1;
    localparam int CEN_W = SUM_W + 1;
    localparam int SCL_W = (CEN_W + SHIFT > OUT_W + 1) ? CEN_W + SHIFT : OUT_W + 1;

    localparam logic [15:0]              c_poly      = 16'hB400;
    localparam logic [15:0]              c_seed_safe = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [CNT_W-1:0]         c_last_fill = CNT_W'(N_TAPS - 1);
    localparam logic signed [CEN_W-1:0]  c_mid       = CEN_W'(N_TAPS) <<< (U_W - 1);
    localparam logic signed [SCL_W-1:0]  c_max       = {{(SCL_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [SCL_W-1:0]  c_min       = ~c_max;

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;
    logic [CNT_W-1:0]            r_fill_cnt;
    logic [N_TAPS-1:0][U_W-1:0]  r_win;
    logic [SUM_W-1:0]            r_sum;
    logic [15:0]                 r_lfsr;
    logic                        r_valid;
    logic [OUT_W-1:0]            r_data;
    logic                        r_sat;

    logic                        w_advance;
    logic                        w_load_out;
    logic [15:0]                 w_lfsr_step;
    logic [U_W-1:0]              w_new;
    logic [U_W-1:0]              w_oldest;
    logic [SUM_W-1:0]            w_sum_next;
    logic signed [CEN_W-1:0]     w_cen;
    logic signed [SCL_W-1:0]     w_scaled;
    logic [OUT_W-1:0]            w_sat_data;
    logic                        w_sat_flag;

    assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_poly : 16'h0000);
    assign w_new       = src_sel ? ext_sample : r_lfsr[15 -: U_W];
    // Oldest slot is still zero while filling; gating it keeps the sum exact regardless.
    assign w_oldest    = (r_state == S_RUN) ? r_win[N_TAPS-1] : '0;
    assign w_sum_next  = r_sum + SUM_W'(w_new) - SUM_W'(w_oldest);
    assign w_cen       = $signed({1'b0, w_sum_next}) - c_mid;
    assign w_scaled    = SCL_W'(w_cen) <<< SHIFT;

    always_comb begin
        w_sat_flag = 1'b0;
        w_sat_data = w_scaled[OUT_W-1:0];
        if (w_scaled > c_max) begin
            w_sat_flag = 1'b1;
            w_sat_data = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (w_scaled < c_min) begin
            w_sat_flag = 1'b1;
            w_sat_data = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load_out   = 1'b0;
        w_advance    = enable & ~seed_load & ((r_state == S_FILL) | ~r_valid | out_if.out_ready);
        if (seed_load) begin
            w_next_state = S_FILL;
        end else if (w_advance) begin
            case (r_state)
                S_FILL: begin
                    if (r_fill_cnt == c_last_fill) begin
                        w_load_out   = 1'b1;
                        w_next_state = S_RUN;
                    end
                end
                S_RUN:   w_load_out   = 1'b1;
                default: w_next_state = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_FILL;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr     <= c_seed_safe;
            r_win      <= '0;
            r_sum      <= '0;
            r_fill_cnt <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_sat      <= 1'b0;
        end else if (seed_load) begin
            r_lfsr     <= (seed_in == 16'h0000) ? 16'h0001 : seed_in;
            r_win      <= '0;
            r_sum      <= '0;
            r_fill_cnt <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_sat      <= 1'b0;
        end else if (w_advance) begin
            r_lfsr <= w_lfsr_step;
            r_win  <= {r_win[N_TAPS-2:0], w_new};
            r_sum  <= w_sum_next;
            if (r_state == S_FILL) r_fill_cnt <= r_fill_cnt + CNT_W'(1);
            if (w_load_out) begin
                r_valid <= 1'b1;
                r_data  <= w_sat_data;
                r_sat   <= w_sat_flag;
            end
        end
    end

    assign out_if.out_valid = r_valid;
    assign out_if.out_data  = r_data;
    assign out_if.out_sat   = r_sat;
endmodule
`default_nettype wire

// File: tb/tb_gaussian_clt_stream.sv
`default_nettype none
// Bench: four parameterisations share one stimulus stream; each is tracked by a
// window-queue model that re-sums the whole window every step.
module tb_gaussian_clt_stream;
    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        src_sel = 1'b0;
    logic [7:0]  ext_sample = 8'h00;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic        out_ready = 1'b0;

    logic [NI-1:0]        vld;
    logic [NI-1:0]        sat;
    logic [NI-1:0][15:0]  dat;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int NT = (g == 2) ? 3 : (g == 3) ? 64 : 12;
        localparam int SH = (g == 1) ? 5 : 4;

        gaussian_clt_stream_if #(.OUT_W(16)) bus ();
        assign bus.out_ready = out_ready;
        assign vld[g] = bus.out_valid;
        assign sat[g] = bus.out_sat;
        assign dat[g] = bus.out_data;

        gaussian_clt_stream #(
            .N_TAPS(NT), .U_W(8), .OUT_W(16), .SHIFT(SH), .SEED(16'hACE1)
        ) dut (
            .clk(clk), .rst_n(rst_n), .enable(enable), .src_sel(src_sel),
            .ext_sample(ext_sample), .seed_load(seed_load), .seed_in(seed_in),
            .out_if(bus.master)
        );

        logic [7:0]  q[$];
        logic [15:0] m_lfsr;
        logic        m_valid;
        logic        m_sat;
        logic [15:0] m_data;
        int          m_sum;
        int          m_s;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q.delete();
                m_lfsr  = 16'hACE1;
                m_valid = 1'b0;
                m_data  = 16'h0000;
                m_sat   = 1'b0;
            end else if (seed_load) begin
                q.delete();
                m_lfsr  = (seed_in == 16'h0000) ? 16'h0001 : seed_in;
                m_valid = 1'b0;
                m_data  = 16'h0000;
                m_sat   = 1'b0;
            end else if (enable && (!m_valid || out_ready)) begin
                q.push_back(src_sel ? ext_sample : m_lfsr[15:8]);
                m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
                if (q.size() > NT) void'(q.pop_front());
                if (q.size() == NT) begin
                    m_sum = 0;
                    foreach (q[k]) m_sum += int'(q[k]);
                    m_s = (m_sum - NT * 128) * (1 << SH);
                    m_valid = 1'b1;
                    if (m_s > 32767) begin
                        m_data = 16'h7FFF; m_sat = 1'b1;
                    end else if (m_s < -32768) begin
                        m_data = 16'h8000; m_sat = 1'b1;
                    end else begin
                        m_data = 16'(m_s); m_sat = 1'b0;
                    end
                end
            end
        end

        always @(negedge clk) begin
            check($sformatf("valid[%0d]", g), 32'(vld[g]), 32'(m_valid));
            check($sformatf("data[%0d]", g),  32'(dat[g]), 32'(m_data));
            check($sformatf("sat[%0d]", g),   32'(sat[g]), 32'(m_sat));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_valid[%0d]", i), 32'(vld[i]), 32'd0);
            check($sformatf("rst_data[%0d]", i),  32'(dat[i]), 32'd0);
            check($sformatf("rst_sat[%0d]", i),   32'(sat[i]), 32'd0);
        end
        #4 rst_n = 1'b1;
    endtask

    initial begin
        cycles(2);
        rst_n = 1'b1; enable = 1'b1; out_ready = 1'b1; src_sel = 1'b1; ext_sample = 8'hFF;
        for (int k = 1; k <= 12; k++) begin
            cycles(1);
            check($sformatf("fill_valid_edge%0d", k), 32'(vld[0]), 32'(k == 12));
        end
        check("ff_data",     32'(dat[0]), 32'h5F40);
        check("ff_sat",      32'(sat[0]), 32'd0);
        check("ff_sh5_data", 32'(dat[1]), 32'h7FFF);
        check("ff_sh5_sat",  32'(sat[1]), 32'd1);

        ext_sample = 8'h00;
        cycles(12);
        check("zero_data",     32'(dat[0]), 32'hA000);
        check("zero_sat",      32'(sat[0]), 32'd0);
        check("zero_sh5_data", 32'(dat[1]), 32'h8000);
        check("zero_sh5_sat",  32'(sat[1]), 32'd1);

        ext_sample = 8'h80;
        cycles(11);
        check("mid_data_11", 32'(dat[0] != 16'h0000), 32'd1);
        cycles(1);
        check("mid_data_12", 32'(dat[0]), 32'h0000);
        check("mid_sat_12",  32'(sat[0]), 32'd0);

        seed_load = 1'b1; seed_in = 16'h0000; src_sel = 1'b0;
        cycles(1);
        seed_load = 1'b0;
        for (int i = 0; i < NI; i++) check($sformatf("seed_drop[%0d]", i), 32'(vld[i]), 32'd0);
        for (int k = 1; k <= 12; k++) begin
            cycles(1);
            check($sformatf("refill_valid_edge%0d", k), 32'(vld[0]), 32'(k == 12));
        end
        check("seed1_data",     32'(dat[0]), 32'hB640);
        check("seed1_sat",      32'(sat[0]), 32'd0);
        check("seed1_sh5_data", 32'(dat[1]), 32'h8000);

        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycles(1);
            check("stall_data",  32'(dat[0]), 32'hB640);
            check("stall_valid", 32'(vld[0]), 32'd1);
        end
        out_ready = 1'b1;

        for (int i = 0; i < 10000; i++) begin
            cycles(1);
            if (i == 5000) reset_pulse();
            enable     = ($urandom_range(7) != 0);
            src_sel    = ($urandom_range(9) == 0);
            ext_sample = 8'($urandom);
            out_ready  = ($urandom_range(3) != 0);
            seed_load  = ($urandom_range(499) == 0);
            seed_in    = ($urandom_range(3) == 0) ? 16'h0000 : 16'($urandom);
        end
        seed_load = 1'b0;
        cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
